// File: rtl/ps2_cmd_decoder_pkg.sv
// Shared definitions for the PS/2 command decoder: scan codes, held-bitmap
// bit positions, prefix FSM encoding and the scan-code-to-key map.
package ps2_cmd_decoder_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;

  // Final codes used by the game
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Bit positions in the held bitmap and the command vector.
  // The auto-repeating keys occupy the low indices so a timer index maps
  // directly onto a key index.
  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_DOWN   = 2;
  localparam int KEY_ROTATE = 3;
  localparam int KEY_DROP   = 4;
  localparam int KEY_START  = 5;
  localparam int NUM_KEYS   = 6;
  localparam int NUM_REPEAT = 3;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  // Prefix FSM: what has been seen since the last final code
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_e;

  // Auto-repeat timer phase: waiting for the first repeat, or repeating
  typedef enum logic {
    PH_DELAY,
    PH_RATE
  } repeat_phase_e;

  // Map a final code (plus whether it was E0-prefixed) onto a one-hot key
  // vector. Unmapped codes give all zeros.
  function automatic key_vec_t key_decode(input logic ext, input logic [7:0] code);
    key_vec_t k;
    k = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  k[KEY_LEFT]   = 1'b1;
        SC_RIGHT: k[KEY_RIGHT]  = 1'b1;
        SC_DOWN:  k[KEY_DOWN]   = 1'b1;
        SC_UP:    k[KEY_ROTATE] = 1'b1;
        default:  k = '0;
      endcase
    end else begin
      case (code)
        SC_LSHIFT: k[KEY_ROTATE] = 1'b1;
        SC_SPACE:  k[KEY_DROP]   = 1'b1;
        SC_ENTER:  k[KEY_START]  = 1'b1;
        default:   k = '0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_cmd_decoder_key_repeat_timer.sv
// Auto-repeat timer for one movement key: a counter plus a delay/rate phase.
// The counter runs only while enabled; tick is asserted in the cycle the
// counter reaches the end of the current phase, so the registered command
// pulse lands exactly REPEAT_DELAY (then REPEAT_RATE) cycles after the make.
module key_repeat_timer
  import ps2_cmd_decoder_pkg::*;
#(
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 2_500_000,
  parameter int CNT_W        = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] cnt_q;
  repeat_phase_e    phase_q;
  logic [CNT_W-1:0] cnt_last;

  // Select the terminal count for the current phase and flag the tick
  always_comb begin
    cnt_last = (phase_q == PH_RATE) ? RATE_LAST : DELAY_LAST;
    tick     = enable && (cnt_q == cnt_last);
  end

  // Counter/phase register: held at 0 in delay phase whenever not running
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= PH_DELAY;
    end else if (flush || restart || !enable) begin
      cnt_q   <= '0;
      phase_q <= PH_DELAY;
    end else if (tick) begin
      cnt_q   <= '0;
      phase_q <= PH_RATE;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code stream to one-cycle tetris command pulses. Tracks E0/F0
// prefixes, keeps a held-key bitmap (which swallows typematic repeats) and
// generates its own auto-repeat for left, right and down.
module ps2_cmd_decoder
  import ps2_cmd_decoder_pkg::*;
#(
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 2_500_000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [7:0] scan_byte,
  input  logic       flush,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_down,
  output logic       cmd_rotate,
  output logic       cmd_drop,
  output logic       cmd_start,
  output logic [5:0] held
);

  prefix_state_e state_q;
  prefix_state_e state_d;

  key_vec_t code_keys;   // key addressed by scan_byte in the current prefix context
  key_vec_t make_vec;    // fresh presses this cycle (not already held)
  key_vec_t brk_vec;     // releases this cycle
  key_vec_t held_q;
  key_vec_t cmd_q;
  key_vec_t rep_vec;

  logic [NUM_REPEAT-1:0] rep_en;
  logic [NUM_REPEAT-1:0] rep_tick;
  logic                  lr_both;

  assign code_keys = key_decode((state_q == ST_EXT) || (state_q == ST_EXT_BRK), scan_byte);

  // Prefix FSM next state and make/break decode of final codes
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    make_vec = '0;
    brk_vec  = '0;
    if (scan_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_byte == SC_EXT) begin
            state_d = ST_EXT;
          end else if (scan_byte == SC_BRK) begin
            state_d = ST_BRK;
          end else begin
            make_vec = code_keys & ~held_q;
            state_d  = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (scan_byte == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            make_vec = code_keys & ~held_q;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_vec = code_keys;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_vec = code_keys;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Prefix state register; flush drops any partial sequence and the byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Repeat enables: left and right cancel each other while both are held
  always_comb begin
    lr_both              = held_q[KEY_LEFT] && held_q[KEY_RIGHT];
    rep_en               = '0;
    rep_en[KEY_LEFT]     = held_q[KEY_LEFT]  && !lr_both;
    rep_en[KEY_RIGHT]    = held_q[KEY_RIGHT] && !lr_both;
    rep_en[KEY_DOWN]     = held_q[KEY_DOWN];
  end

  for (genvar i = 0; i < NUM_REPEAT; i++) begin : g_rep
    key_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .CNT_W        (CNT_W)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .restart (make_vec[i]),
      .enable  (rep_en[i]),
      .tick    (rep_tick[i])
    );
  end

  assign rep_vec = {{(NUM_KEYS-NUM_REPEAT){1'b0}}, rep_tick};

  // Registered commands and held bitmap; a break masks a same-cycle repeat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q  <= '0;
      held_q <= '0;
    end else if (flush) begin
      cmd_q  <= '0;
      held_q <= '0;
    end else begin
      cmd_q  <= make_vec | (rep_vec & ~brk_vec);
      held_q <= (held_q | make_vec) & ~brk_vec;
    end
  end

  assign cmd_left   = cmd_q[KEY_LEFT];
  assign cmd_right  = cmd_q[KEY_RIGHT];
  assign cmd_down   = cmd_q[KEY_DOWN];
  assign cmd_rotate = cmd_q[KEY_ROTATE];
  assign cmd_drop   = cmd_q[KEY_DROP];
  assign cmd_start  = cmd_q[KEY_START];
  assign held       = held_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder with short repeat timings.
module tb_ps2_cmd_decoder;

  localparam int D  = 10;
  localparam int R  = 4;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_byte = 8'h00;
  logic       flush = 1'b0;
  logic       cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop, cmd_start;
  logic [5:0] held;
  logic [5:0] cmd;

  assign cmd = {cmd_start, cmd_drop, cmd_rotate, cmd_down, cmd_right, cmd_left};

  ps2_cmd_decoder #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_valid (scan_valid),
    .scan_byte  (scan_byte),
    .flush      (flush),
    .cmd_left   (cmd_left),
    .cmd_right  (cmd_right),
    .cmd_down   (cmd_down),
    .cmd_rotate (cmd_rotate),
    .cmd_drop   (cmd_drop),
    .cmd_start  (cmd_start),
    .held       (held)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: prefix flags, held set, and absolute due cycle of the
  // next repeat pulse for left/right/down.
  bit         m_ext, m_brk;
  logic [5:0] m_held;
  int         due [3];

  typedef struct {
    bit         v;
    logic [7:0] b;
    bit         f;
    logic [5:0] ec;
    logic [5:0] eh;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int key_of(input bit ext, input logic [7:0] c);
    if (ext) begin
      if (c == 8'h6B) return 0;
      if (c == 8'h74) return 1;
      if (c == 8'h72) return 2;
      if (c == 8'h75) return 3;
    end else begin
      if (c == 8'h12) return 3;
      if (c == 8'h29) return 4;
      if (c == 8'h5A) return 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = '0;
    for (int i = 0; i < 3; i++) due[i] = 0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic step(input bit v, input logic [7:0] b, input bit f);
    logic [5:0] pre, mk, br, exp;
    int k;
    bit sup, run;
    scan_valid = v; scan_byte = b; flush = f;
    cyc++;
    pre = m_held; mk = '0; br = '0; exp = '0;
    if (f) begin
      m_ext = 0; m_brk = 0; m_held = '0;
    end else begin
      if (v) begin
        if (b == 8'hE0 && !m_ext && !m_brk) m_ext = 1;
        else if (b == 8'hF0 && !m_brk) m_brk = 1;
        else begin
          k = key_of(m_ext, b);
          if (k >= 0) begin
            if (m_brk) br[k] = 1'b1;
            else if (!pre[k]) mk[k] = 1'b1;
          end
          m_ext = 0; m_brk = 0;
        end
      end
      sup = pre[0] && pre[1];
      for (int i = 0; i < 3; i++) begin
        run = pre[i] && !(sup && i < 2);
        if (run && cyc == due[i] && !br[i]) exp[i] = 1'b1;
        if (mk[i] || (sup && i < 2)) due[i] = cyc + D;
        else if (exp[i]) due[i] = cyc + R;
      end
      exp = exp | mk;
      m_held = (pre | mk) & ~br;
    end
    @(posedge clk); #1;
    scan_valid = 0; flush = 0;
    check("model_cmd", {26'd0, cmd}, {26'd0, exp});
    check("model_held", {26'd0, held}, {26'd0, m_held});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #2;
    check("reset_cmd", {26'd0, cmd}, 32'd0);
    check("reset_held", {26'd0, held}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic add(input bit v, input logic [7:0] b, input bit f,
                     input logic [5:0] ec, input logic [5:0] eh);
    vec_t t;
    t.v = v; t.b = b; t.f = f; t.ec = ec; t.eh = eh;
    tbl.push_back(t);
  endtask

  initial begin
    int mk, mr, md, r, cnt_l, cnt_r, cnt_d;
    int pl[$];
    int exp_rep[6];
    logic [7:0] pool[14];
    exp_rep = '{0, 10, 14, 18, 22, 26};
    pool = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h6B, 8'h74, 8'h72,
             8'h75, 8'h12, 8'h29, 8'h5A, 8'hAA, 8'hFA, 8'h1C};

    #1;
    do_reset();

    // ---- Table-driven vectors ----
    add(1,8'hE0,0,6'h00,6'h00); add(1,8'h6B,0,6'h01,6'h01);   // left make
    add(1,8'hE0,0,6'h00,6'h01); add(1,8'hF0,0,6'h00,6'h01);
    add(1,8'h6B,0,6'h00,6'h00);                                // left break
    add(1,8'h6B,0,6'h00,6'h00);                                // plain 6B unmapped
    add(1,8'h12,0,6'h08,6'h08);                                // L-shift rotate
    add(1,8'hE0,0,6'h00,6'h08); add(1,8'h75,0,6'h00,6'h08);   // second rotate source
    add(1,8'hF0,0,6'h00,6'h08); add(1,8'h12,0,6'h00,6'h00);   // release clears shared bit
    add(1,8'h29,0,6'h10,6'h10); add(1,8'h5A,0,6'h20,6'h30);   // drop, start
    add(1,8'hF0,0,6'h00,6'h30); add(1,8'h29,0,6'h00,6'h20);
    add(1,8'hF0,0,6'h00,6'h20); add(1,8'h5A,0,6'h00,6'h00);
    add(1,8'hE0,0,6'h00,6'h00); add(1,8'h72,0,6'h04,6'h04);   // down make
    add(1,8'hE0,0,6'h00,6'h04); add(1,8'h72,0,6'h00,6'h04);   // typematic
    add(1,8'hE0,0,6'h00,6'h04); add(1,8'h72,0,6'h00,6'h04);   // typematic
    add(1,8'hE0,0,6'h00,6'h04); add(1,8'hF0,0,6'h00,6'h04);
    add(1,8'h72,0,6'h00,6'h00);
    add(1,8'hAA,0,6'h00,6'h00); add(1,8'hFA,0,6'h00,6'h00);
    add(1,8'hEE,0,6'h00,6'h00); add(1,8'hFE,0,6'h00,6'h00);
    add(1,8'h6B,0,6'h00,6'h00);                                // still in IDLE
    add(1,8'hE0,0,6'h00,6'h00); add(1,8'h6B,1,6'h00,6'h00);   // flush drops byte
    add(1,8'h6B,0,6'h00,6'h00);                                // treated as plain
    add(1,8'h29,0,6'h10,6'h10); add(0,8'h00,1,6'h00,6'h00);   // flush clears held
    add(1,8'hE0,0,6'h00,6'h00); add(1,8'h74,0,6'h02,6'h02);
    add(0,8'h00,1,6'h00,6'h00);
    add(1,8'hE0,0,6'h00,6'h00); add(1,8'h74,0,6'h02,6'h02);   // re-make after flush
    add(0,8'h00,1,6'h00,6'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].f);
      check($sformatf("tbl_cmd[%0d]", i), {26'd0, cmd}, {26'd0, tbl[i].ec});
      check($sformatf("tbl_held[%0d]", i), {26'd0, held}, {26'd0, tbl[i].eh});
    end

    // ---- Hold left: repeat schedule, break at +28 ----
    step(1, 8'hE0, 0); step(1, 8'h6B, 0);
    mk = cyc;
    if (cmd_left) pl.push_back(cyc - mk);
    for (int c = 1; c <= 40; c++) begin
      if (c == 26)      step(1, 8'hE0, 0);
      else if (c == 27) step(1, 8'hF0, 0);
      else if (c == 28) step(1, 8'h6B, 0);
      else              step(0, 8'h00, 0);
      if (cmd_left) pl.push_back(cyc - mk);
    end
    check("hold_left_count", pl.size(), 6);
    for (int i = 0; i < 6 && i < pl.size(); i++)
      check($sformatf("hold_left_pulse[%0d]", i), pl[i], exp_rep[i]);

    // ---- Left and right together: suppression, then release left ----
    step(1, 8'hE0, 0); step(1, 8'h6B, 0); mk = cyc;
    check("lr_left_make", {31'd0, cmd_left}, 32'd1);
    step(1, 8'hE0, 0); step(1, 8'h74, 0); mr = cyc;
    check("lr_right_make", {31'd0, cmd_right}, 32'd1);
    cnt_l = 0; cnt_r = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 8'h00, 0);
      cnt_l += int'(cmd_left); cnt_r += int'(cmd_right);
    end
    check("lr_suppressed_left", cnt_l, 0);
    check("lr_suppressed_right", cnt_r, 0);
    step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h6B, 0); r = cyc;
    check("lr_held_after_release", {26'd0, held}, 32'h02);
    pl.delete();
    for (int i = 0; i < 15; i++) begin
      step(0, 8'h00, 0);
      if (cmd_right) pl.push_back(cyc - r);
    end
    check("lr_resume_count", pl.size(), 2);
    if (pl.size() > 0) check("lr_resume_first", pl[0], 10);
    if (pl.size() > 1) check("lr_resume_second", pl[1], 14);
    step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h74, 0);

    // ---- Break on the same cycle as the first repeat tick ----
    step(1, 8'hE0, 0); step(1, 8'h72, 0); md = cyc;
    cnt_d = int'(cmd_down);
    for (int c = 1; c <= 14; c++) begin
      if (c == 8)       step(1, 8'hE0, 0);
      else if (c == 9)  step(1, 8'hF0, 0);
      else if (c == 10) step(1, 8'h72, 0);
      else              step(0, 8'h00, 0);
      if (c == 10) check("break_vs_tick", {31'd0, cmd_down}, 32'd0);
      cnt_d += int'(cmd_down);
    end
    check("break_vs_tick_total", cnt_d, 1);

    // ---- Reset in the middle of a prefix ----
    step(1, 8'hE0, 0);
    do_reset();
    step(1, 8'h6B, 0);
    check("reset_prefix_cmd", {26'd0, cmd}, 32'd0);
    check("reset_prefix_held", {26'd0, held}, 32'd0);

    // ---- Randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 5) == 0, pool[$urandom_range(0, 13)],
           $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_decoder.md
# ps2_cmd_decoder

Converts the raw PS/2 scan-code byte stream into clean, one-cycle game command pulses for the tetris game FSM. It tracks make, break and extended (E0) prefixes, and keeps a held-key bitmap. It generates its own auto-repeat for movement keys and ignores the keyboard's typematic repeats. It sits between the PS/2 receiver (byte output) and the tetris control logic (state transitions, pos_x/pos_y/rotation updates).

## Interface
Parameters:
- REPEAT_DELAY, 12_500_000: cycles from the make pulse to the first auto-repeat pulse (0.25 s at 50 MHz).
- REPEAT_RATE, 2_500_000: cycles between subsequent auto-repeat pulses (50 ms).
- CNT_W, 24: repeat counter width. Must satisfy 2^CNT_W > REPEAT_DELAY.

Ports:
- clk  in  1  system clock, 50 MHz; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- scan_valid  in  1  one-cycle strobe; scan_byte is valid.
- scan_byte  in  8  received PS/2 byte.
- flush  in  1  synchronous clear of the prefix state, the held bitmap and the counters. No pulses are emitted.
- cmd_left  out  1  one-cycle pulse: move left.
- cmd_right  out  1  one-cycle pulse: move right.
- cmd_down  out  1  one-cycle pulse: soft drop.
- cmd_rotate  out  1  one-cycle pulse: rotate.
- cmd_drop  out  1  one-cycle pulse: hard drop.
- cmd_start  out  1  one-cycle pulse: start/restart.
- held  out  6  level bitmap {start,drop,rotate,down,right,left}.

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Each transition happens only on scan_valid.
  - IDLE: E0 goes to EXT; F0 goes to BRK.
  - EXT: F0 goes to EXT_BRK.
  - Any other byte is a final code: it is decoded and the FSM returns to IDLE.
- Key map:
  - E0 6B: left.
  - E0 74: right.
  - E0 72: down.
  - E0 75 or plain 12 (L-shift): rotate.
  - plain 29 (space): drop.
  - plain 5A (enter): start.
  - An E0 code in plain form (e.g. plain 6B, keypad 4) is not mapped.
- Make of key k:
  - If held[k] is 0: set held[k], pulse cmd_k, and clear k's repeat counter.
  - If held[k] is 1 (typematic repeat): no pulse.
- Break of key k: clear held[k]. No pulse.
- The two rotate sources share one held bit. Releasing either source clears it.
- Unmapped codes, and bytes AA/FA/EE/FE received in IDLE, cause no output change and leave the FSM in IDLE.
- Auto-repeat applies to left, right and down only. Each has its own CNT_W counter running while its held bit is set.
  - A pulse is issued when the counter reaches REPEAT_DELAY−1 the first time.
  - After that, a pulse is issued every REPEAT_RATE cycles.
- Left and right both held: auto-repeat is suppressed for both, and their counters hold at 0. Make pulses are still issued.
- Rotate, drop and start never auto-repeat.

## Timing
- Reset and flush values:
  - All cmd_* outputs are 0 and held is 0.
  - The FSM is in IDLE and all counters are 0.
  - Reset mid-prefix discards the partial sequence.
- Latency: scan_valid with the final byte at cycle t gives the cmd pulse and the held update at t+1. All outputs are registered.
- The first repeat pulse falls exactly REPEAT_DELAY cycles after the make pulse. Following pulses fall every REPEAT_RATE cycles.
- Break in the same cycle as a repeat tick: the break wins and no pulse is issued.
- A make pulse and a repeat tick never coincide for the same key, because the counter restarts on make.
- Each cmd output is high for at most 1 cycle per event. Different keys may pulse in the same cycle.
- flush has priority over a simultaneous scan_valid; that byte is dropped.
- Back-to-back scan_valid on consecutive cycles must be accepted.

## Structure
- Shared package holds:
  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_LEFT=6B, SC_RIGHT=74, SC_DOWN=72, SC_UP=75, SC_LSHIFT=12, SC_SPACE=29, SC_ENTER=5A.
  - held bit indices.
  - Prefix FSM state encoding.
- One natural sub-module, key_repeat_timer: one counter plus the delay/rate phase, instantiated three times (left, right, down).

## Test plan
(Bench parameters: REPEAT_DELAY=10, REPEAT_RATE=4.)
- Send E0,6B → one cmd_left pulse 1 cycle after the 6B strobe; held=000001. Then send E0,F0,6B → held=0, no pulse.
- Hold left 30 cycles → pulses at make+0, +10, +14, +18, +22, +26. Break at cycle 28 → no further pulses.
- Send E0,6B; E0,6B; E0,6B (typematic) → exactly one pulse.
- Hold left, then make right → right pulses once; no repeats on either key while both are held. Release left → right repeats at +10 from the release.
- Send plain 6B, then plain 12 → no cmd_left; cmd_rotate once. Send F0,12 → held[3]=0.
- Send E0, then assert rst (or flush) → then 6B → no pulse; the FSM treated 6B as plain.
